stage5_ctrl_fsm: RTL and testbench
==================================

Name: stage5_ctrl_fsm

Overview:
- Multicycle control unit that sequences the Stage5 ALU datapath: source-A/B muxes, ALU op, ALU output register, status register (SR).
- Also sequences the fetch, memory and writeback strobes around Stage5.
- Moore FSM driven by the 4-bit opcode from the instruction register, the 2-bit SR flags and a memory-ready handshake.
- Sits beside the datapath top level; all outputs drive datapath enables and mux selects directly.

Parameters:
- OPW, 4, opcode width.
- HALT_ON_ILLEGAL, 0: 1 = illegal opcode enters S_HALT; 0 = treated as NOP and returns to S_FETCH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces S_IDLE immediately.
- opcode  in  4  IR[15:12]; sampled in S_DECODE.
- SRout  in  2  status flags from Stage5: bit1 = zero, bit0 = negative.
- mem_ready  in  1  memory done; qualifies S_FETCH, S_MEM_RD, S_MEM_WR.
- IRw  out  1  instruction register write.
- PCw  out  1  PC write.
- PCsrc  out  1  0 = ALU output register, 1 = jump target.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IorD  out  1  0 = PC address, 1 = ALU output address.
- MDRw  out  1  memory data register write.
- RegWrite  out  1  register file write.
- MemToReg  out  1  writeback source: 0 = ALU output, 1 = MDR.
- ALUsrcA  out  2  00 MDRout, 01 immGenOut, 10 CCout (PC), 11 zero.
- ALUsrcB  out  2  00 constant 2, 01 reggieOut, 10 immGenOut, 11 zero.
- ALUop  out  2  00 add, 01 and, 10 or, 11 sub (B - A).
- ALU_in  out  1  ALU output register load.
- SRw  out  1  status register write.
- illegal  out  1  one-cycle pulse in S_DECODE on an undefined opcode.
- state_dbg  out  4  current state encoding.

Behaviour:
- Outputs are pure decode of the registered state (Moore). Any output not listed for a state is 0.
- Reset / S_IDLE: all outputs 0, state_dbg = 0. The next edge after reset deasserts goes to S_FETCH.
- S_FETCH: MemRead, IorD=0, IRw, ALUsrcA=10, ALUsrcB=00, ALUop=00, PCw, PCsrc=0.
  - Held while mem_ready=0; IRw and PCw are gated by mem_ready so the PC advances exactly once.
  - mem_ready=1 -> S_DECODE.
- S_DECODE: ALUsrcA=10, ALUsrcB=10, ALUop=00, ALU_in (branch target precompute). Next state by opcode:
  - 0 ADD, 1 SUB, 2 AND, 3 OR -> S_EXEC_R.
  - 4 ADDI -> S_EXEC_I.
  - 5 LW, 6 SW -> S_MEM_ADDR.
  - 7 BEQ, 8 BNE -> S_BR_CMP.
  - 9 JMP -> S_JUMP.
  - F HALT -> S_HALT.
  - Others: assert illegal; go to S_FETCH, or S_HALT if HALT_ON_ILLEGAL=1.
- S_EXEC_R: ALUsrcA=00, ALUsrcB=01, ALUop = op map (ADD 00, SUB 11, AND 01, OR 10), ALU_in, SRw -> S_ALU_WB.
- S_EXEC_I: ALUsrcA=01, ALUsrcB=01, ALUop=00, ALU_in, SRw -> S_ALU_WB.
- S_ALU_WB: RegWrite, MemToReg=0 -> S_FETCH.
- S_MEM_ADDR: ALUsrcA=01, ALUsrcB=01, ALUop=00, ALU_in; SRw=0. LW -> S_MEM_RD; SW -> S_MEM_WR.
- S_MEM_RD: MemRead, IorD=1, MDRw gated by mem_ready. Stays until mem_ready=1 -> S_MEM_WB.
- S_MEM_WB: RegWrite, MemToReg=1 -> S_FETCH.
- S_MEM_WR: MemWrite, IorD=1. Stays until mem_ready=1 -> S_FETCH.
- S_BR_CMP: ALUsrcA=00, ALUsrcB=01, ALUop=11, SRw; ALU_in=0 so the branch target is held -> S_BR_RES.
- S_BR_RES: uses the SR value written in S_BR_CMP.
  - Taken if (BEQ and SRout[1]) or (BNE and !SRout[1]); then PCw=1, PCsrc=0.
  - Opcode is held in an internal register latched in S_DECODE -> S_FETCH.
- S_JUMP: PCw, PCsrc=1 -> S_FETCH.
- S_HALT: all outputs 0; absorbing until reset.
- Latency in cycles, excluding memory wait states: R/I 4, LW 5, SW 4, BEQ/BNE 4, JMP 3.
- SRw is asserted only in S_EXEC_R, S_EXEC_I and S_BR_CMP. ALU_in is never asserted in the same state as PCsrc=1.
- Reset mid-instruction, including during a mem_ready wait: all outputs drop to 0 asynchronously and the in-flight instruction is discarded.
- mem_ready high outside memory states is ignored.

Decomposition:
- Package stage5_ctrl_pkg holds:
  - state encodings (S_IDLE=0 through S_HALT=13);
  - opcode constants;
  - ALUop, ALUsrcA and ALUsrcB encodings.
- One sub-module, stage5_ctrl_decode: combinational state+opcode -> control-word decode. The FSM top keeps only the state and latched-opcode registers plus next-state logic.

Test Plan:
- Reset, then opcode=0 (ADD), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH. In EXEC_R: ALUsrcA=00, ALUsrcB=01, ALUop=00, ALU_in=1, SRw=1. RegWrite=1 exactly one cycle.
- SUB with MDRout = reggieOut = 16'hABCD on the live Stage5 -> ALU output 16'h0000 and SRout=2'b10 after ALU_WB.
- LW with mem_ready held low 3 cycles in S_MEM_RD -> state_dbg constant, MDRw=0 throughout. MDRw=1 on the ready cycle. Total 8 cycles fetch-to-fetch.
- BEQ with SRout[1]=1 after BR_CMP -> PCw=1 in BR_RES. Same stimulus with BNE -> PCw=0.
- Opcode 4'hC with HALT_ON_ILLEGAL=0 -> illegal pulses 1 cycle, back in FETCH. With HALT_ON_ILLEGAL=1 -> S_HALT held for 10 cycles, all outputs 0.
- Assert reset mid-S_MEM_WR -> MemWrite falls in the same timestep without a clock edge, state_dbg=0; resumes at FETCH after release.

Source files
------------

// File: rtl/stage5_ctrl_pkg.sv
// Shared encodings for the Stage5 multicycle controller: FSM states, opcodes
// and the datapath mux/ALU select codes.
package stage5_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BR_CMP   = 4'd10,
        S_BR_RES   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic [1:0] SRCA_MDR  = 2'b00;
    localparam logic [1:0] SRCA_IMM  = 2'b01;
    localparam logic [1:0] SRCA_PC   = 2'b10;
    localparam logic [1:0] SRCA_ZERO = 2'b11;

    localparam logic [1:0] SRCB_TWO  = 2'b00;
    localparam logic [1:0] SRCB_REG  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    function automatic logic op_defined(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic [1:0] r_alu_op(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/stage5_ctrl_decode.sv
// Control-word decode: maps the current state (plus latched opcode, zero flag
// and mem_ready for the gated strobes) onto datapath enables and selects.
module stage5_ctrl_decode
    import stage5_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [3:0] opcode,
    input  logic [3:0] op_reg,
    input  logic       sr_zero,
    input  logic       mem_ready,
    output logic       IRw,
    output logic       PCw,
    output logic       PCsrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       MDRw,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] ALUop,
    output logic       ALU_in,
    output logic       SRw,
    output logic       illegal
);

    logic br_taken;

    assign br_taken = ((op_reg == OP_BEQ) && sr_zero) ||
                      ((op_reg == OP_BNE) && !sr_zero);

    always_comb begin
        IRw      = 1'b0;
        PCw      = 1'b0;
        PCsrc    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        MDRw     = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUsrcA  = SRCA_MDR;
        ALUsrcB  = SRCB_TWO;
        ALUop    = ALU_ADD;
        ALU_in   = 1'b0;
        SRw      = 1'b0;
        illegal  = 1'b0;
        case (state_t'(state))
            S_FETCH: begin
                // IR/PC writes wait for the memory so PC+2 is taken only once
                MemRead = 1'b1;
                IRw     = mem_ready;
                PCw     = mem_ready;
                ALUsrcA = SRCA_PC;
                ALUsrcB = SRCB_TWO;
            end
            S_DECODE: begin
                ALUsrcA = SRCA_PC;
                ALUsrcB = SRCB_IMM;
                ALU_in  = 1'b1;
                illegal = !op_defined(opcode);
            end
            S_EXEC_R: begin
                ALUsrcA = SRCA_MDR;
                ALUsrcB = SRCB_REG;
                ALUop   = r_alu_op(op_reg);
                ALU_in  = 1'b1;
                SRw     = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALUsrcA = SRCA_IMM;
                ALUsrcB = SRCB_REG;
                ALU_in  = 1'b1;
                SRw     = (state_t'(state) == S_EXEC_I);
            end
            S_ALU_WB: RegWrite = 1'b1;
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                MDRw    = mem_ready;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BR_CMP: begin
                // ALU_in stays low so the target computed in decode survives
                ALUsrcA = SRCA_MDR;
                ALUsrcB = SRCB_REG;
                ALUop   = ALU_SUB;
                SRw     = 1'b1;
            end
            S_BR_RES: PCw = br_taken;
            S_JUMP: begin
                PCw   = 1'b1;
                PCsrc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage5_ctrl_fsm.sv
// Multicycle control FSM for the Stage5 datapath: holds the state and the
// opcode latched in decode; all outputs come from stage5_ctrl_decode.
module stage5_ctrl_fsm
    import stage5_ctrl_pkg::*;
#(
    parameter int OPW             = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [1:0]     SRout,
    input  logic           mem_ready,
    output logic           IRw,
    output logic           PCw,
    output logic           PCsrc,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IorD,
    output logic           MDRw,
    output logic           RegWrite,
    output logic           MemToReg,
    output logic [1:0]     ALUsrcA,
    output logic [1:0]     ALUsrcB,
    output logic [1:0]     ALUop,
    output logic           ALU_in,
    output logic           SRw,
    output logic           illegal,
    output logic [3:0]     state_dbg
);

    state_t     state_reg;
    logic [3:0] op_reg;
    logic [3:0] op_now;
    logic       sr_neg_unused;

    assign op_now        = 4'(opcode);
    assign sr_neg_unused = SRout[0];
    assign state_dbg     = state_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE:  state_reg <= S_FETCH;
                S_FETCH: if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    op_reg <= op_now;
                    case (op_now)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: state_reg <= S_EXEC_R;
                        OP_ADDI:        state_reg <= S_EXEC_I;
                        OP_LW, OP_SW:   state_reg <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_reg <= S_BR_CMP;
                        OP_JMP:         state_reg <= S_JUMP;
                        OP_HALT:        state_reg <= S_HALT;
                        default: begin
                            if (HALT_ON_ILLEGAL) state_reg <= S_HALT;
                            else                 state_reg <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_reg <= S_ALU_WB;
                S_ALU_WB:           state_reg <= S_FETCH;
                S_MEM_ADDR: begin
                    if (op_reg == OP_SW) state_reg <= S_MEM_WR;
                    else                 state_reg <= S_MEM_RD;
                end
                S_MEM_RD: if (mem_ready) state_reg <= S_MEM_WB;
                S_MEM_WB:           state_reg <= S_FETCH;
                S_MEM_WR: if (mem_ready) state_reg <= S_FETCH;
                S_BR_CMP:           state_reg <= S_BR_RES;
                S_BR_RES, S_JUMP:   state_reg <= S_FETCH;
                S_HALT:             state_reg <= S_HALT;
                default:            state_reg <= S_IDLE;
            endcase
        end
    end

    stage5_ctrl_decode u_decode (
        .state     (state_reg),
        .opcode    (op_now),
        .op_reg    (op_reg),
        .sr_zero   (SRout[1]),
        .mem_ready (mem_ready),
        .IRw       (IRw),
        .PCw       (PCw),
        .PCsrc     (PCsrc),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .MDRw      (MDRw),
        .RegWrite  (RegWrite),
        .MemToReg  (MemToReg),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ALUop     (ALUop),
        .ALU_in    (ALU_in),
        .SRw       (SRw),
        .illegal   (illegal)
    );

endmodule

// File: tb/tb_stage5_ctrl_fsm.sv
// Bench for stage5_ctrl_fsm: directed sequences, a vector table and random
// instructions scored against an instruction-level reference model.
module tb_stage5_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       reset, reset_h;
    logic [3:0] opcode, opcode_h;
    logic [1:0] SRout;
    logic       mem_ready;

    logic IRw, PCw, PCsrc, MemRead, MemWrite, IorD, MDRw, RegWrite, MemToReg;
    logic [1:0] ALUsrcA, ALUsrcB, ALUop;
    logic ALU_in, SRw, illegal;
    logic [3:0] state_dbg;

    logic h_IRw, h_PCw, h_PCsrc, h_MemRead, h_MemWrite, h_IorD, h_MDRw, h_RegWrite, h_MemToReg;
    logic [1:0] h_ALUsrcA, h_ALUsrcB, h_ALUop;
    logic h_ALU_in, h_SRw, h_illegal;
    logic [3:0] h_state_dbg;

    logic [21:0] outs, outs_h;
    assign outs   = {IRw, PCw, PCsrc, MemRead, MemWrite, IorD, MDRw, RegWrite, MemToReg,
                     ALUsrcA, ALUsrcB, ALUop, ALU_in, SRw, illegal, state_dbg};
    assign outs_h = {h_IRw, h_PCw, h_PCsrc, h_MemRead, h_MemWrite, h_IorD, h_MDRw, h_RegWrite,
                     h_MemToReg, h_ALUsrcA, h_ALUsrcB, h_ALUop, h_ALU_in, h_SRw, h_illegal, h_state_dbg};

    always #5 CLK = ~CLK;

    stage5_ctrl_fsm #(.OPW(4), .HALT_ON_ILLEGAL(1'b0)) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .SRout(SRout), .mem_ready(mem_ready),
        .IRw(IRw), .PCw(PCw), .PCsrc(PCsrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .MDRw(MDRw), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .ALU_in(ALU_in),
        .SRw(SRw), .illegal(illegal), .state_dbg(state_dbg)
    );

    stage5_ctrl_fsm #(.OPW(4), .HALT_ON_ILLEGAL(1'b1)) dut_halt (
        .CLK(CLK), .reset(reset_h), .opcode(opcode_h), .SRout(SRout), .mem_ready(mem_ready),
        .IRw(h_IRw), .PCw(h_PCw), .PCsrc(h_PCsrc), .MemRead(h_MemRead), .MemWrite(h_MemWrite),
        .IorD(h_IorD), .MDRw(h_MDRw), .RegWrite(h_RegWrite), .MemToReg(h_MemToReg),
        .ALUsrcA(h_ALUsrcA), .ALUsrcB(h_ALUsrcB), .ALUop(h_ALUop), .ALU_in(h_ALU_in),
        .SRw(h_SRw), .illegal(h_illegal), .state_dbg(h_state_dbg)
    );

    typedef struct {
        int cycles, pcw, regw, srw, aluin, mdrw, memw, memr, ill;
    } cnt_t;

    typedef struct {
        logic [3:0] op;
        logic [1:0] sr;
        int         wf, wm;
        cnt_t       exp;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   inv_viol = 0;
    vec_t tbl[13];
    int   add_st[4] = '{1, 2, 3, 5};
    int   lw_st[8]  = '{1, 2, 6, 7, 7, 7, 7, 8};
    logic lw_mr[8]  = '{1, 1, 1, 0, 0, 0, 1, 1};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [1:0] sr, input int wf, input int wm,
                                input int cyc, input int pcw, input int regw, input int srw,
                                input int aluin, input int mdrw, input int memw, input int memr,
                                input int ill);
        vec_t v;
        v.op = op; v.sr = sr; v.wf = wf; v.wm = wm;
        v.exp.cycles = cyc; v.exp.pcw = pcw; v.exp.regw = regw; v.exp.srw = srw;
        v.exp.aluin = aluin; v.exp.mdrw = mdrw; v.exp.memw = memw; v.exp.memr = memr;
        v.exp.ill = ill;
        return v;
    endfunction

    // Instruction-level expectations: latency and strobe counts per instruction class
    function automatic cnt_t model(input logic [3:0] op, input logic [1:0] sr, input int wf, input int wm);
        cnt_t e;
        bit   alu_cls, lw, sw, br, jmp, ill, taken;
        alu_cls = (op <= 4'h4);
        lw      = (op == 4'h5);
        sw      = (op == 4'h6);
        br      = (op == 4'h7) || (op == 4'h8);
        jmp     = (op == 4'h9);
        ill     = (op >= 4'hA) && (op <= 4'hE);
        taken   = ((op == 4'h7) && sr[1]) || ((op == 4'h8) && !sr[1]);
        e.cycles = (alu_cls ? 4 : lw ? 5 : sw ? 4 : br ? 4 : jmp ? 3 : 2) + wf + ((lw || sw) ? wm : 0);
        e.pcw    = 1 + int'(jmp) + int'(taken);
        e.regw   = int'(alu_cls || lw);
        e.srw    = int'(alu_cls || br);
        e.aluin  = 1 + int'(alu_cls || lw || sw);
        e.mdrw   = int'(lw);
        e.memw   = sw ? wm + 1 : 0;
        e.memr   = wf + 1 + (lw ? wm + 1 : 0);
        e.ill    = int'(ill);
        return e;
    endfunction

    function automatic logic mr_at(input int off, input int wf, input int wm, input bit is_mem);
        if (off < wf) return 1'b0;
        if (off == wf) return 1'b1;
        if (is_mem && off >= wf + 3 && off < wf + 3 + wm) return 1'b0;
        if (is_mem && off == wf + 3 + wm) return 1'b1;
        return 1'($urandom & 1);
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic [1:0] sr, input int wf, input int wm,
                             output cnt_t c);
        bit seen_dec;
        int off;
        c = '{default: 0};
        opcode   = op;
        SRout    = sr;
        seen_dec = 1'b0;
        off      = 0;
        while (!(seen_dec && state_dbg == 4'd1) && off < 40) begin
            mem_ready = mr_at(off, wf, wm, (op == 4'h5) || (op == 4'h6));
            @(negedge CLK);
            if (state_dbg == 4'd2) seen_dec = 1'b1;
            c.cycles++;
            c.pcw   += int'(PCw);
            c.regw  += int'(RegWrite);
            c.srw   += int'(SRw);
            c.aluin += int'(ALU_in);
            c.mdrw  += int'(MDRw);
            c.memw  += int'(MemWrite);
            c.memr  += int'(MemRead);
            c.ill   += int'(illegal);
            if (ALU_in && PCsrc) inv_viol++;
            @(posedge CLK);
            #1;
            off++;
        end
        check("end_in_fetch", int'(state_dbg), 1);
    endtask

    task automatic cmp_cnt(input string tag, input cnt_t a, input cnt_t e);
        check({tag, ".cycles"}, a.cycles, e.cycles);
        check({tag, ".pcw"},    a.pcw,    e.pcw);
        check({tag, ".regw"},   a.regw,   e.regw);
        check({tag, ".srw"},    a.srw,    e.srw);
        check({tag, ".aluin"},  a.aluin,  e.aluin);
        check({tag, ".mdrw"},   a.mdrw,   e.mdrw);
        check({tag, ".memw"},   a.memw,   e.memw);
        check({tag, ".memr"},   a.memr,   e.memr);
        check({tag, ".ill"},    a.ill,    e.ill);
    endtask

    initial begin
        cnt_t c, e;
        logic [3:0] rop;
        logic [1:0] rsr;
        int rwf, rwm, regw_cnt;

        //           op    sr     wf wm cyc pcw rw srw ain mdr mw mr ill
        tbl[0]  = mk(4'h0, 2'b00, 0, 0, 4, 1, 1, 1, 2, 0, 0, 1, 0);
        tbl[1]  = mk(4'h1, 2'b01, 2, 0, 6, 1, 1, 1, 2, 0, 0, 3, 0);
        tbl[2]  = mk(4'h2, 2'b00, 0, 0, 4, 1, 1, 1, 2, 0, 0, 1, 0);
        tbl[3]  = mk(4'h4, 2'b00, 1, 0, 5, 1, 1, 1, 2, 0, 0, 2, 0);
        tbl[4]  = mk(4'h5, 2'b00, 0, 3, 8, 1, 1, 0, 2, 1, 0, 5, 0);
        tbl[5]  = mk(4'h6, 2'b00, 1, 2, 7, 1, 0, 0, 2, 0, 3, 2, 0);
        tbl[6]  = mk(4'h7, 2'b10, 0, 0, 4, 2, 0, 1, 1, 0, 0, 1, 0);
        tbl[7]  = mk(4'h7, 2'b00, 0, 0, 4, 1, 0, 1, 1, 0, 0, 1, 0);
        tbl[8]  = mk(4'h8, 2'b10, 0, 0, 4, 1, 0, 1, 1, 0, 0, 1, 0);
        tbl[9]  = mk(4'h8, 2'b00, 0, 0, 4, 2, 0, 1, 1, 0, 0, 1, 0);
        tbl[10] = mk(4'h9, 2'b00, 0, 0, 3, 2, 0, 0, 1, 0, 0, 1, 0);
        tbl[11] = mk(4'hC, 2'b00, 0, 0, 2, 1, 0, 0, 1, 0, 0, 1, 1);
        tbl[12] = mk(4'hA, 2'b01, 1, 0, 3, 1, 0, 0, 1, 0, 0, 2, 1);

        reset = 1'b1; reset_h = 1'b1;
        opcode = 4'h0; opcode_h = 4'h0; SRout = 2'b00; mem_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_outs", int'(outs), 0);
        check("reset_outs_h", int'(outs_h), 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        check("idle_after_release", int'(state_dbg), 0);
        @(posedge CLK); #1;
        $display("reset done, state=%0d", state_dbg);

        // ADD walk: FETCH, DECODE, EXEC_R, ALU_WB, FETCH
        opcode = 4'h0; regw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge CLK);
            check("add_state", int'(state_dbg), add_st[i]);
            if (i == 2) begin
                check("add_exec_srcA", int'(ALUsrcA), 0);
                check("add_exec_srcB", int'(ALUsrcB), 1);
                check("add_exec_aluop", int'(ALUop), 0);
                check("add_exec_aluin", int'(ALU_in), 1);
                check("add_exec_srw", int'(SRw), 1);
            end
            regw_cnt += int'(RegWrite);
            @(posedge CLK); #1;
        end
        check("add_back_fetch", int'(state_dbg), 1);
        check("add_regwrite_once", regw_cnt, 1);
        $display("ADD walk done");

        opcode = 4'h1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            @(negedge CLK);
            if (i == 2) begin
                check("sub_exec_state", int'(state_dbg), 3);
                check("sub_exec_aluop", int'(ALUop), 3);
            end
            @(posedge CLK); #1;
        end
        $display("SUB walk done");

        // LW with three wait states in MEM_RD
        opcode = 4'h5;
        for (int i = 0; i < 8; i++) begin
            mem_ready = lw_mr[i];
            @(negedge CLK);
            check("lw_state", int'(state_dbg), lw_st[i]);
            if (i >= 3 && i <= 5) check("lw_mdrw_wait", int'(MDRw), 0);
            if (i == 6) check("lw_mdrw_ready", int'(MDRw), 1);
            @(posedge CLK); #1;
        end
        check("lw_back_fetch", int'(state_dbg), 1);
        $display("LW wait walk done");

        // Asynchronous reset while waiting in MEM_WR
        opcode = 4'h6;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            @(negedge CLK);
            if (i < 3) begin
                @(posedge CLK); #1;
            end
        end
        check("sw_wr_state", int'(state_dbg), 9);
        check("sw_memwrite_hi", int'(MemWrite), 1);
        reset = 1'b1;
        #1;
        check("async_rst_memwrite", int'(MemWrite), 0);
        check("async_rst_state", int'(state_dbg), 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        check("resume_fetch", int'(state_dbg), 1);
        $display("async reset in MEM_WR done");

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].sr, tbl[i].wf, tbl[i].wm, c);
            cmp_cnt($sformatf("vec%0d", i), c, tbl[i].exp);
            $display("vec %0d op=%h sr=%b wf=%0d wm=%0d cycles=%0d pcw=%0d",
                     i, tbl[i].op, tbl[i].sr, tbl[i].wf, tbl[i].wm, c.cycles, c.pcw);
        end

        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 14));
            rsr = 2'($urandom_range(0, 3));
            rwf = $urandom_range(0, 3);
            rwm = $urandom_range(0, 3);
            e = model(rop, rsr, rwf, rwm);
            run_instr(rop, rsr, rwf, rwm, c);
            cmp_cnt($sformatf("rnd%0d", n), c, e);
            $display("rnd %0d op=%h sr=%b wf=%0d wm=%0d cycles=%0d", n, rop, rsr, rwf, rwm, c.cycles);
        end
        check("alu_in_pcsrc_excl", inv_viol, 0);

        // HALT_ON_ILLEGAL=1 instance: illegal opcode parks in S_HALT
        reset = 1'b1;
        opcode_h = 4'hC;
        reset_h = 1'b0;
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        @(negedge CLK);
        check("halt_inst_fetch", int'(h_state_dbg), 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("halt_inst_illegal", int'(h_illegal), 1);
        @(posedge CLK); #1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom & 1);
            @(negedge CLK);
            check("halt_state", int'(h_state_dbg), 13);
            check("halt_outs_zero", int'(outs_h[21:4]), 0);
            @(posedge CLK); #1;
        end
        $display("halt-on-illegal sequence done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
